// File: rtl/or_gate_pkg.sv
// Shared definitions for the or_gate block.
//   DEFAULT_WIDTH : default operand width used by or_gate and or_gate_core
//   or_word_t     : operand word of DEFAULT_WIDTH bits
package or_gate_pkg;

  localparam int DEFAULT_WIDTH = 1;

  typedef logic [DEFAULT_WIDTH-1:0] or_word_t;

endpackage : or_gate_pkg

// File: rtl/or_gate_core.sv
// Purely combinational bitwise OR of two equal-width operands.
// Ports:
//   a, b : operands (WIDTH bits)
//   y    : a | b (WIDTH bits, no width growth)
module or_gate_core
  import or_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule : or_gate_core

// File: rtl/or_gate.sv
// Bitwise 2-input OR with an optional registered output stage.
// Ports:
//   clk   : system clock, rising edge active
//   rst   : synchronous active-high reset
//   a, b  : operands (WIDTH bits)
//   en    : capture enable (only meaningful when REGISTERED=1)
//   x     : bitwise OR result (WIDTH bits)
//   x_any : reduction OR of x
//   valid : x was updated with new data this cycle (constant 1 when combinational)
// Parameters:
//   WIDTH      : operand/result width, 1..64
//   REGISTERED : 1 = x registered with 1-cycle latency, 0 = x combinational
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] x,
  output logic             x_any,
  output logic             valid
);

  // Stage p0: combinational OR of the current operands
  logic [WIDTH-1:0] or_p0;

  or_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (a),
    .b (b),
    .y (or_p0)
  );

  if (REGISTERED) begin : g_reg
    // Stage p1: captured result; x holds its value whenever en is low
    logic [WIDTH-1:0] x_p1;
    logic             vld_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        x_p1   <= '0;
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= en;
        if (en) begin
          x_p1 <= or_p0;
        end
      end
    end

    assign x     = x_p1;
    assign valid = vld_p1;
  end else begin : g_comb
    // Clock, reset and enable have no effect on a purely combinational OR.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};

    assign x     = or_p0;
    assign valid = 1'b1;
  end

  // Derived straight from x so it is 0 whenever x is 0, including after reset
  assign x_any = |x;

endmodule : or_gate

// File: tb/tb_or_gate.sv
module tb_or_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic [0:0] x_c1, x_r1;
  logic [7:0] x_c8, x_r8;
  logic       any_c1, any_r1, any_c8, any_r8;
  logic       vld_c1, vld_r1, vld_c8, vld_r8;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state for the registered instances
  logic [7:0] exp_x8;
  logic [0:0] exp_x1;
  logic       exp_vld;

  always #5 clk = ~clk;

  or_gate #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en),
    .x(x_c1), .x_any(any_c1), .valid(vld_c1));

  or_gate #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en),
    .x(x_r1), .x_any(any_r1), .valid(vld_r1));

  or_gate #(.WIDTH(8), .REGISTERED(1'b0)) u_c8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
    .x(x_c8), .x_any(any_c8), .valid(vld_c8));

  or_gate #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
    .x(x_r8), .x_any(any_r8), .valid(vld_r8));

  // OR via inclusion-exclusion: |A u B| = |A| + |B| - |A n B| per bit position
  function automatic logic [63:0] or_ref(input logic [63:0] p, input logic [63:0] q);
    return (p + q) - (p & q);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check combinational outputs,
  // advance the model on the rising edge, then check registered outputs.
  task automatic step(input logic r, input logic e, input logic [7:0] pa, input logic [7:0] pb);
    logic [63:0] c1, c8;
    @(negedge clk);
    rst = r; en = e; a8 = pa; b8 = pb; a1 = pa[0]; b1 = pb[0];
    #1;
    c1 = or_ref(64'(pa[0]), 64'(pb[0]));
    c8 = or_ref(64'(pa), 64'(pb));
    check("c1_x",     64'(x_c1),   c1);
    check("c1_any",   64'(any_c1), 64'(c1 != 0));
    check("c1_valid", 64'(vld_c1), 64'd1);
    check("c8_x",     64'(x_c8),   c8);
    check("c8_any",   64'(any_c8), 64'(c8 != 0));
    check("c8_valid", 64'(vld_c8), 64'd1);

    @(posedge clk);
    if (r) begin
      exp_x1  = '0;
      exp_x8  = '0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = e;
      if (e) begin
        exp_x1 = c1[0:0];
        exp_x8 = c8[7:0];
      end
    end
    #1;
    check("r1_x",     64'(x_r1),   64'(exp_x1));
    check("r1_any",   64'(any_r1), 64'(exp_x1 != 0));
    check("r1_valid", 64'(vld_r1), 64'(exp_vld));
    check("r8_x",     64'(x_r8),   64'(exp_x8));
    check("r8_any",   64'(any_r8), 64'(exp_x8 != 0));
    check("r8_valid", 64'(vld_r8), 64'(exp_vld));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    exp_x1 = '0; exp_x8 = '0; exp_vld = 1'b0;

    // reset state
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 8'h5A, 8'hC3);

    // single-bit truth table, enabled every cycle
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h01);

    // 8-bit merge, then all-zero result
    step(1'b0, 1'b1, 8'hA0, 8'h05);
    step(1'b0, 1'b1, 8'h00, 8'h00);

    // hold with en low
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b0, 8'h01, 8'h02);
    step(1'b0, 1'b0, 8'h01, 8'h02);

    // reset overrides en, then first enabled capture
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);

    // randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(15) == 0), 1'($urandom_range(1)),
           8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_or_gate
